atm_session_ctrl: RTL and testbench
===================================

Name: atm_session_ctrl

Overview:
- Keypad-facing session FSM directly upstream of the account authenticator.
- Captures an account nibble, then a PIN nibble, and drives the authenticator's acc_number/pin/action/deAuth inputs. Samples its combinational wasSuccessful/accIndex result and owns the login session.
- Counts failed PIN attempts and locks the terminal after MAX_TRIES failures.
- Downstream transaction logic consumes session_active/session_acc_index.

Parameters:
- MAX_TRIES, 3, failed PIN attempts before lockout (1..7).
- LOCK_CYCLES, 5000, clocks spent in LOCKED before returning to IDLE.
- TIMEOUT_CYCLES, 1000, inactivity limit in PIN_ENTRY/SESSION (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- key_valid  in  1  one-cycle strobe; key_data is a keyed nibble.
- key_data  in  4  keyed nibble.
- key_enter  in  1  one-cycle strobe; commit the current entry.
- key_cancel  in  1  one-cycle strobe; abort entry or log out.
- auth_acc_number  out  4  to authenticator acc_number.
- auth_pin  out  4  to authenticator pin.
- auth_action  out  1  to authenticator action: 0 = FIND, 1 = AUTHENTICATE.
- auth_deauth  out  1  to authenticator deAuth; one-cycle pulse.
- auth_success  in  1  from authenticator wasSuccessful.
- auth_acc_index  in  4  from authenticator accIndex.
- session_active  out  1  high while in SESSION.
- session_acc_index  out  4  index latched at successful login.
- card_locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse on unknown account or bad PIN.
- state_dbg  out  3  current state encoding.

Behaviour:
- Reset values: all outputs 0, state IDLE, tries 0, entry_valid 0, all counters 0. Reset mid-operation aborts immediately to IDLE with no deauth pulse.
- Entry register: key_valid loads key_data into entry and sets entry_valid; the last key wins.
- Strobe priority when simultaneous: key_cancel > key_enter > key_valid.
- key_enter with entry_valid=0 is ignored. entry_valid clears on every state change.
- State encoding: IDLE=0, FIND=1, CHK_ACC=2, PIN_ENTRY=3, AUTH=4, CHK_PIN=5, SESSION=6, LOCKED=7. LOGOUT is folded into SESSION exit via a registered deauth pulse.
- IDLE: key_enter with entry_valid loads auth_acc_number=entry, sets auth_action=0, goes to FIND. key_cancel clears the entry.
- FIND: one settle cycle for the combinational authenticator, then CHK_ACC.
- CHK_ACC: sample auth_success.
  - 1: go to PIN_ENTRY.
  - 0: pulse err_pulse and go to IDLE.
- PIN_ENTRY:
  - key_enter with entry_valid loads auth_pin=entry, sets auth_action=1, goes to AUTH.
  - key_cancel goes to IDLE with tries cleared.
- AUTH: one settle cycle, then CHK_PIN.
- CHK_PIN:
  - auth_success=1: latch session_acc_index=auth_acc_index, clear tries, go to SESSION. Latency from the PIN key_enter to session_active=1 is 3 clocks.
  - auth_success=0: tries+1 and pulse err_pulse. If tries+1==MAX_TRIES, go to LOCKED; otherwise go back to PIN_ENTRY.
- SESSION:
  - key_cancel: auth_deauth=1 for exactly one cycle (registered, next clock). Clear session_active, session_acc_index, auth_pin and auth_action. Go to IDLE.
  - key_valid and key_enter are ignored.
- LOCKED:
  - lock_cnt counts 0..LOCK_CYCLES-1; all keys including cancel are ignored.
  - At terminal count, clear tries and go to IDLE.
- auth_* outputs are registered and hold their value between updates.
- Counter width: clog2 of the largest of LOCK_CYCLES and TIMEOUT_CYCLES, plus 1. The tries width holds MAX_TRIES.

Optional Feature:
- Macro: ATM_SESSION_TIMEOUT_EN.
- With the macro: an inactivity counter runs in PIN_ENTRY and SESSION and resets on any key strobe or state change. On reaching TIMEOUT_CYCLES:
  - in PIN_ENTRY, go to IDLE;
  - in SESSION, perform the cancel/logout sequence, including the auth_deauth pulse.
- Without the macro: no counter is built, TIMEOUT_CYCLES is unused, and states persist indefinitely.

Decomposition:
- Package atm_pkg holds the state enum (3-bit), ACT_FIND=1'b0, ACT_AUTH=1'b1, and the NIBBLE_W=4 constant.
- One sub-module is natural: atm_cycle_counter, a parameterised load/clear/terminal-count counter. It is instanced for lock_cnt and, under the macro, for the timeout counter.

Test Plan:
- Enter acc 2 then PIN 2 (authenticator match) -> auth_action goes 0 then 1, session_active=1 three clocks after the PIN enter, session_acc_index=2, err_pulse never asserted.
- Enter acc 9 (no match) -> err_pulse one cycle at CHK_ACC, state_dbg returns to 0, auth_action stays 0.
- Acc 1 then three wrong PINs (5, 6, 7) with MAX_TRIES=3 -> err_pulse three times, card_locked=1. Keys are ignored for LOCK_CYCLES=20 (test override), then IDLE with tries=0.
- SESSION with key_cancel and key_enter in the same cycle -> cancel wins, auth_deauth high for exactly 1 cycle, session_active=0 the next clock.
- rst_n low for 1 cycle while in AUTH -> next clock all outputs are 0 and state is IDLE; the enter sequence then works normally.
- With ATM_SESSION_TIMEOUT_EN and TIMEOUT_CYCLES=10 -> a SESSION with no keys for 10 clocks yields an auth_deauth pulse and IDLE. Without the macro the session persists for 100 clocks.

Source files
------------

// File: rtl/atm_session_ctrl_pkg.sv
// Shared types and constants for the ATM session controller.
package atm_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic ACT_FIND = 1'b0;
  localparam logic ACT_AUTH = 1'b1;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StFind     = 3'd1,
    StChkAcc   = 3'd2,
    StPinEntry = 3'd3,
    StAuth     = 3'd4,
    StChkPin   = 3'd5,
    StSession  = 3'd6,
    StLocked   = 3'd7
  } atm_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Keypad, authenticator and session signals of the ATM session controller.
// master: the controller; slave: keypad/authenticator/transaction side.
interface atm_session_ctrl_if;
  import atm_pkg::*;

  logic                key_valid;
  logic [NIBBLE_W-1:0] key_data;
  logic                key_enter;
  logic                key_cancel;
  logic [NIBBLE_W-1:0] auth_acc_number;
  logic [NIBBLE_W-1:0] auth_pin;
  logic                auth_action;
  logic                auth_deauth;
  logic                auth_success;
  logic [NIBBLE_W-1:0] auth_acc_index;
  logic                session_active;
  logic [NIBBLE_W-1:0] session_acc_index;
  logic                card_locked;
  logic                err_pulse;
  logic [2:0]          state_dbg;

  modport master (
    input  key_valid, key_data, key_enter, key_cancel, auth_success, auth_acc_index,
    output auth_acc_number, auth_pin, auth_action, auth_deauth,
    output session_active, session_acc_index, card_locked, err_pulse, state_dbg
  );

  modport slave (
    output key_valid, key_data, key_enter, key_cancel, auth_success, auth_acc_index,
    input  auth_acc_number, auth_pin, auth_action, auth_deauth,
    input  session_active, session_acc_index, card_locked, err_pulse, state_dbg
  );

endinterface

// File: rtl/atm_session_ctrl_cycle_counter.sv
// Clearable/loadable cycle counter with terminal count at LIMIT-1 (wraps to 0).
module atm_cycle_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == WIDTH'(LIMIT - 1));

  // Next count: clear beats load beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/atm_session_ctrl.sv
// Keypad-facing login session FSM in front of the account authenticator.
// Optional inactivity timeout: define ATM_SESSION_TIMEOUT_EN.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCK_CYCLES    = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic               clk,
  input logic               rst_n,
  atm_session_ctrl_if.master bus
);

  localparam int unsigned CNT_W   = $clog2(max_u(LOCK_CYCLES, TIMEOUT_CYCLES)) + 1;
  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);

  atm_state_e          state_q, state_d;
  logic [NIBBLE_W-1:0] entry_q, entry_d;
  logic                entry_valid_q, entry_valid_d;
  logic [TRIES_W-1:0]  tries_q, tries_d, tries_inc;
  logic [NIBBLE_W-1:0] acc_q, acc_d;
  logic [NIBBLE_W-1:0] pin_q, pin_d;
  logic                action_q, action_d;
  logic                deauth_q, deauth_d;
  logic [NIBBLE_W-1:0] sess_idx_q, sess_idx_d;
  logic                err;
  logic                lock_tc;
  logic                timeout_tc;

  assign tries_inc = tries_q + TRIES_W'(1);

  atm_cycle_counter #(
    .WIDTH (CNT_W),
    .LIMIT (LOCK_CYCLES)
  ) u_lock_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q != StLocked),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .en_i       (1'b1),
    .tc_o       (lock_tc)
  );

`ifdef ATM_SESSION_TIMEOUT_EN
  logic timed_state;
  logic any_key;

  assign timed_state = (state_q == StPinEntry) || (state_q == StSession);
  assign any_key     = bus.key_valid || bus.key_enter || bus.key_cancel;

  // Both timed states are entered from untimed ones, so the counter is already
  // zero on entry; clearing outside them covers the state-change restart.
  atm_cycle_counter #(
    .WIDTH (CNT_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (!timed_state || any_key),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .en_i       (1'b1),
    .tc_o       (timeout_tc)
  );
`else
  assign timeout_tc = 1'b0;
`endif

  // Next-state, entry capture and authenticator drive; cancel > enter > valid.
  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    entry_valid_d = entry_valid_q;
    tries_d       = tries_q;
    acc_d         = acc_q;
    pin_d         = pin_q;
    action_d      = action_q;
    deauth_d      = 1'b0;
    sess_idx_d    = sess_idx_q;
    err           = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.key_cancel) begin
          entry_d       = '0;
          entry_valid_d = 1'b0;
        end else if (bus.key_enter && entry_valid_q) begin
          acc_d    = entry_q;
          action_d = ACT_FIND;
          state_d  = StFind;
        end else if (bus.key_valid) begin
          entry_d       = bus.key_data;
          entry_valid_d = 1'b1;
        end
      end
      StFind: state_d = StChkAcc;
      StChkAcc: begin
        if (bus.auth_success) begin
          state_d = StPinEntry;
        end else begin
          err     = 1'b1;
          state_d = StIdle;
        end
      end
      StPinEntry: begin
        if (bus.key_cancel) begin
          tries_d = '0;
          state_d = StIdle;
        end else if (bus.key_enter && entry_valid_q) begin
          pin_d    = entry_q;
          action_d = ACT_AUTH;
          state_d  = StAuth;
        end else if (bus.key_valid) begin
          entry_d       = bus.key_data;
          entry_valid_d = 1'b1;
        end else if (timeout_tc) begin
          tries_d = '0;
          state_d = StIdle;
        end
      end
      StAuth: state_d = StChkPin;
      StChkPin: begin
        if (bus.auth_success) begin
          sess_idx_d = bus.auth_acc_index;
          tries_d    = '0;
          state_d    = StSession;
        end else begin
          err     = 1'b1;
          tries_d = tries_inc;
          state_d = (tries_inc == TRIES_W'(MAX_TRIES)) ? StLocked : StPinEntry;
        end
      end
      StSession: begin
        if (bus.key_cancel || timeout_tc) begin
          deauth_d   = 1'b1;
          sess_idx_d = '0;
          pin_d      = '0;
          action_d   = ACT_FIND;
          state_d    = StIdle;
        end
      end
      StLocked: begin
        if (lock_tc) begin
          tries_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A half-typed entry never carries over into the next state.
    if (state_d != state_q) entry_valid_d = 1'b0;
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      entry_q       <= '0;
      entry_valid_q <= 1'b0;
      tries_q       <= '0;
      acc_q         <= '0;
      pin_q         <= '0;
      action_q      <= ACT_FIND;
      deauth_q      <= 1'b0;
      sess_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      entry_valid_q <= entry_valid_d;
      tries_q       <= tries_d;
      acc_q         <= acc_d;
      pin_q         <= pin_d;
      action_q      <= action_d;
      deauth_q      <= deauth_d;
      sess_idx_q    <= sess_idx_d;
    end
  end

  assign bus.auth_acc_number   = acc_q;
  assign bus.auth_pin          = pin_q;
  assign bus.auth_action       = action_q;
  assign bus.auth_deauth       = deauth_q;
  assign bus.session_active    = (state_q == StSession);
  assign bus.session_acc_index = sess_idx_q;
  assign bus.card_locked       = (state_q == StLocked);
  assign bus.err_pulse         = err;
  assign bus.state_dbg         = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: directed scenarios plus randomized login attempts.
// Expected output events (error, login, logout, lock, unlock) are queued by the
// stimulus from a user-level model; a negedge monitor pops and compares them.
module tb_atm_session_ctrl;
  import atm_pkg::*;

  localparam int unsigned MAX_TRIES      = 3;
  localparam int unsigned LOCK_CYCLES    = 20;
  localparam int unsigned TIMEOUT_CYCLES = 10;

  localparam int EV_ERR    = 1;
  localparam int EV_SESS   = 2;
  localparam int EV_DEAUTH = 3;
  localparam int EV_LOCK   = 4;
  localparam int EV_UNLOCK = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q[$];
  int   m_tries = 0;
  bit   mon_prev_sess = 1'b0;
  bit   mon_prev_lock = 1'b0;

  atm_session_ctrl_if bus ();

  atm_session_ctrl #(
    .MAX_TRIES      (MAX_TRIES),
    .LOCK_CYCLES    (LOCK_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Authenticator stand-in: accounts 0..7 exist, PIN equals account, index equals account.
  assign bus.auth_success = (bus.auth_action == ACT_FIND) ? (bus.auth_acc_number < 4'd8)
      : ((bus.auth_acc_number < 4'd8) && (bus.auth_pin == bus.auth_acc_number));
  assign bus.auth_acc_index = bus.auth_acc_number;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input int ev);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected: got event %0d expected none (t=%0t)", ev, $time);
    end else begin
      e = exp_q.pop_front();
      if (e != ev) begin
        failures++;
        $display("FAIL event_order: got event %0d expected %0d (t=%0t)", ev, e, $time);
      end
    end
  endtask

  // Monitor: turn output activity into events and check them against the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.err_pulse) observe(EV_ERR * 16);
        if (bus.session_active && !mon_prev_sess)
          observe(EV_SESS * 16 + int'(bus.session_acc_index));
        if (bus.auth_deauth) observe(EV_DEAUTH * 16);
        if (bus.card_locked && !mon_prev_lock) observe(EV_LOCK * 16);
        if (!bus.card_locked && mon_prev_lock) observe(EV_UNLOCK * 16);
      end
      mon_prev_sess = bus.session_active;
      mon_prev_lock = bus.card_locked;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input bit v, input logic [3:0] d, input bit e, input bit c);
    bus.key_valid  = v;
    bus.key_data   = d;
    bus.key_enter  = e;
    bus.key_cancel = c;
    @(posedge clk);
    #1;
    bus.key_valid  = 1'b0;
    bus.key_data   = 4'h0;
    bus.key_enter  = 1'b0;
    bus.key_cancel = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc"},      int'(bus.auth_acc_number), 0);
    check({tag, "_pin"},      int'(bus.auth_pin), 0);
    check({tag, "_action"},   int'(bus.auth_action), 0);
    check({tag, "_deauth"},   int'(bus.auth_deauth), 0);
    check({tag, "_active"},   int'(bus.session_active), 0);
    check({tag, "_idx"},      int'(bus.session_acc_index), 0);
    check({tag, "_locked"},   int'(bus.card_locked), 0);
    check({tag, "_err"},      int'(bus.err_pulse), 0);
    check({tag, "_state"},    int'(bus.state_dbg), 0);
  endtask

  task automatic enter_acc(input logic [3:0] acc, output bit ok);
    ok = (int'(acc) < 8);
    if (!ok) exp_q.push_back(EV_ERR * 16);
    strobe(1'b1, acc, 1'b0, 1'b0);
    strobe(1'b0, 4'h0, 1'b1, 1'b0);
    check("acc_state_find", int'(bus.state_dbg), 1);
    check("acc_number",     int'(bus.auth_acc_number), int'(acc));
    check("acc_action",     int'(bus.auth_action), 0);
    idle(2);
    check("acc_result_state", int'(bus.state_dbg), ok ? 3 : 0);
    check("acc_action_hold",  int'(bus.auth_action), 0);
  endtask

  // outcome: 0 = logged in, 1 = retry, 2 = locked out
  task automatic enter_pin(input logic [3:0] acc, input logic [3:0] pin, output int outcome);
    int exp_state;
    if (pin == acc) begin
      outcome = 0;
      m_tries = 0;
      exp_state = 6;
      exp_q.push_back(EV_SESS * 16 + int'(acc));
    end else begin
      m_tries++;
      exp_q.push_back(EV_ERR * 16);
      if (m_tries == int'(MAX_TRIES)) begin
        outcome = 2;
        m_tries = 0;
        exp_state = 7;
        exp_q.push_back(EV_LOCK * 16);
        exp_q.push_back(EV_UNLOCK * 16);
      end else begin
        outcome = 1;
        exp_state = 3;
      end
    end
    strobe(1'b1, pin, 1'b0, 1'b0);
    strobe(1'b0, 4'h0, 1'b1, 1'b0);
    check("pin_state_auth", int'(bus.state_dbg), 4);
    check("pin_action",     int'(bus.auth_action), 1);
    check("pin_value",      int'(bus.auth_pin), int'(pin));
    idle(1);
    check("pin_state_chk",  int'(bus.state_dbg), 5);
    check("pin_early_active", int'(bus.session_active), 0);
    idle(1);
    check("pin_result_state",   int'(bus.state_dbg), exp_state);
    check("pin_session_active", int'(bus.session_active), (outcome == 0) ? 1 : 0);
    if (outcome == 0) check("session_index", int'(bus.session_acc_index), int'(acc));
  endtask

  task automatic wait_lock();
    for (int i = 0; i < int'(LOCK_CYCLES) - 1; i++)
      strobe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("lock_hold",       int'(bus.card_locked), 1);
    check("lock_hold_state", int'(bus.state_dbg), 7);
    idle(1);
    check("unlock_state",  int'(bus.state_dbg), 0);
    check("unlock_locked", int'(bus.card_locked), 0);
  endtask

  task automatic logout(input bit with_enter, input bit with_valid);
    exp_q.push_back(EV_DEAUTH * 16);
    strobe(with_valid, 4'h5, with_enter, 1'b1);
    check("logout_deauth", int'(bus.auth_deauth), 1);
    check("logout_active", int'(bus.session_active), 0);
    check("logout_idx",    int'(bus.session_acc_index), 0);
    check("logout_action", int'(bus.auth_action), 0);
    check("logout_pin",    int'(bus.auth_pin), 0);
    check("logout_state",  int'(bus.state_dbg), 0);
    idle(1);
    check("logout_deauth_single", int'(bus.auth_deauth), 0);
  endtask

  task automatic session_dwell(input int n, input logic [3:0] acc);
    for (int i = 0; i < n; i++) begin
      strobe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      check("dwell_active", int'(bus.session_active), 1);
      check("dwell_idx",    int'(bus.session_acc_index), int'(acc));
    end
  endtask

  initial begin
    bit         ok;
    bit         done;
    int         o;
    logic [3:0] acc;
    logic [3:0] pin;

    bus.key_valid  = 1'b0;
    bus.key_data   = 4'h0;
    bus.key_enter  = 1'b0;
    bus.key_cancel = 1'b0;
    rst_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Good login, then cancel+enter together during the session.
    enter_acc(4'd2, ok);
    enter_pin(4'd2, 4'd2, o);
    logout(1'b1, 1'b0);

    // Unknown account.
    enter_acc(4'd9, ok);

    // Three wrong PINs lock the terminal; keys are ignored while locked.
    enter_acc(4'd1, ok);
    enter_pin(4'd1, 4'd5, o);
    enter_pin(4'd1, 4'd6, o);
    enter_pin(4'd1, 4'd7, o);
    wait_lock();
    strobe(1'b0, 4'h0, 1'b1, 1'b0);
    check("enter_without_entry", int'(bus.state_dbg), 0);

    // Tries were cleared by the unlock: one miss only retries.
    enter_acc(4'd1, ok);
    enter_pin(4'd1, 4'd5, o);
    enter_pin(4'd1, 4'd1, o);
`ifdef ATM_SESSION_TIMEOUT_EN
    exp_q.push_back(EV_DEAUTH * 16);
    idle(int'(TIMEOUT_CYCLES) - 1);
    check("timeout_not_yet", int'(bus.session_active), 1);
    idle(1);
    check("timeout_state",  int'(bus.state_dbg), 0);
    check("timeout_deauth", int'(bus.auth_deauth), 1);
    idle(1);
    check("timeout_deauth_single", int'(bus.auth_deauth), 0);
`else
    idle(100);
    check("session_persists", int'(bus.session_active), 1);
    logout(1'b0, 1'b1);
`endif

    // Reset while in AUTH aborts to IDLE with no deauth.
    enter_acc(4'd2, ok);
    strobe(1'b1, 4'd2, 1'b0, 1'b0);
    strobe(1'b0, 4'h0, 1'b1, 1'b0);
    check("pre_reset_auth", int'(bus.state_dbg), 4);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tries = 0;
    check_all_zero("midreset");
    strobe(1'b0, 4'h0, 1'b1, 1'b0);
    check("post_reset_enter_ignored", int'(bus.state_dbg), 0);
    enter_acc(4'd3, ok);
    enter_pin(4'd3, 4'd3, o);
    logout(1'b0, 1'b0);

    // Randomized users.
    for (int it = 0; it < 30; it++) begin
      acc = 4'($urandom_range(0, 11));
      enter_acc(acc, ok);
      if (ok) begin
        done = 1'b0;
        for (int a = 0; a < 8 && !done; a++) begin
          if ($urandom_range(0, 99) < 15) begin
            strobe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b1);
            m_tries = 0;
            check("pin_cancel_state", int'(bus.state_dbg), 0);
            done = 1'b1;
          end else begin
            pin = ($urandom_range(0, 2) == 0) ? acc : 4'($urandom_range(0, 15));
            enter_pin(acc, pin, o);
            if (o == 0) begin
              session_dwell(int'($urandom_range(0, 5)), acc);
              logout(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
              done = 1'b1;
            end else if (o == 2) begin
              wait_lock();
              done = 1'b1;
            end
          end
        end
        if (!done) begin
          strobe(1'b0, 4'h0, 1'b0, 1'b1);
          m_tries = 0;
        end
      end
    end

    idle(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
